// File: rtl/cpu_core_hs_pkg.sv
// cpu_core_hs_pkg: opcode, branch-condition, state and ALU encodings shared by the core and its ALU.
package cpu_core_hs_pkg;
    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_CMP} alu_fn_e;

    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_LDD  = 5'd2;
    localparam logic [4:0] OP_LDX  = 5'd3;
    localparam logic [4:0] OP_STO  = 5'd4;
    localparam logic [4:0] OP_ADD  = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_CMP  = 5'd7;
    localparam logic [4:0] OP_JMPU = 5'd8;
    localparam logic [4:0] OP_JMPC = 5'd9;
    localparam logic [4:0] OP_HALT = 5'd10;

    localparam logic [2:0] C_EQ  = 3'd0;
    localparam logic [2:0] C_NE  = 3'd1;
    localparam logic [2:0] C_GT  = 3'd2;
    localparam logic [2:0] C_GE  = 3'd3;
    localparam logic [2:0] C_LT  = 3'd4;
    localparam logic [2:0] C_LE  = 3'd5;
    localparam logic [2:0] C_OV  = 3'd6;
    localparam logic [2:0] C_NOV = 3'd7;

    function automatic int step_of(input int word_size);
        return word_size / 8;
    endfunction

    function automatic logic cond_met(input logic [2:0] c, input logic eq, input logic big, input logic ovfl);
        case (c)
            C_EQ:    return eq;
            C_NE:    return !eq;
            C_GT:    return big;
            C_GE:    return big || eq;
            C_LT:    return !big && !eq;
            C_LE:    return !big || eq;
            C_OV:    return ovfl;
            C_NOV:   return !ovfl;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/cpu_alu_p.sv
// cpu_alu_p: combinational add/sub/compare with signed overflow and result flags.
module cpu_alu_p
    import cpu_core_hs_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  alu_fn_e              fn,
    output logic [WORD_SIZE-1:0] result,
    output logic                 ovfl,
    output logic                 eq,
    output logic                 big
);
    localparam int M = WORD_SIZE - 1;
    logic sub;
    assign sub    = fn != ALU_ADD;
    assign result = sub ? a - b : a + b;
    assign ovfl   = (a[M] ^ result[M]) & (sub ? a[M] ^ b[M] : ~(a[M] ^ b[M]));
    // compare is unsigned on the operands; add/sub flag the signed result
    assign eq     = fn == ALU_CMP ? a == b : result == '0;
    assign big    = fn == ALU_CMP ? a > b : !result[M] && result != '0;
endmodule

// File: rtl/cpu_core_hs.sv
// cpu_core_hs: multi-cycle accumulator CPU with a req/ready memory bus and a post-reset memory-clear sweep.
module cpu_core_hs
    import cpu_core_hs_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8,
    parameter int NUM_REGS  = 4,
    parameter int BOOT_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    input  logic                 mem_ready,
    output logic                 boot,
    output logic                 halted
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int STEP_I = step_of(WORD_SIZE);
    localparam logic [ADDR_SIZE-1:0] STEP = ADDR_SIZE'(STEP_I);
    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'((((1 << ADDR_SIZE) - 1) / STEP_I) * STEP_I);

    state_e state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d, baddr_q, baddr_d, addr_d, pc_step;
    logic [WORD_SIZE-1:0] inst_q, inst_d, wdata_d;
    logic [NUM_REGS-1:0][WORD_SIZE-1:0] regs_q, regs_d;
    logic eq_q, eq_d, big_q, big_d, ovfl_q, ovfl_d, req_d, we_d;

    logic [4:0] opcode;
    logic [2:0] fld;
    logic [WORD_SIZE-9:0] opnd;
    logic [RW-1:0] ri, rj;
    assign opcode  = inst_q[WORD_SIZE-1:WORD_SIZE-5];
    assign fld     = inst_q[WORD_SIZE-6:WORD_SIZE-8];
    assign opnd    = inst_q[WORD_SIZE-9:0];
    assign ri      = fld[RW-1:0];
    assign rj      = opnd[RW-1:0];
    assign pc_step = pc_q + STEP;
    assign boot    = state_q == S_BOOT;
    assign halted  = state_q == S_HALT;

    alu_fn_e alu_fn;
    logic [WORD_SIZE-1:0] alu_res;
    logic alu_ovfl, alu_eq, alu_big;
    assign alu_fn = opcode == OP_ADD ? ALU_ADD : opcode == OP_SUB ? ALU_SUB : ALU_CMP;

    cpu_alu_p #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .a(regs_q[ri]), .b(regs_q[rj]), .fn(alu_fn),
        .result(alu_res), .ovfl(alu_ovfl), .eq(alu_eq), .big(alu_big)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT_EN != 0 ? S_BOOT : S_FETCH;
            pc_q      <= '0;
            baddr_q   <= '0;
            inst_q    <= '0;
            regs_q    <= '0;
            eq_q      <= 1'b0;
            big_q     <= 1'b0;
            ovfl_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            baddr_q   <= baddr_d;
            inst_q    <= inst_d;
            regs_q    <= regs_d;
            eq_q      <= eq_d;
            big_q     <= big_d;
            ovfl_q    <= ovfl_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

    // Every bus state raises mem_req only from an idle cycle, so accesses never run back to back.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        baddr_d = baddr_q;
        inst_d  = inst_q;
        regs_d  = regs_q;
        eq_d    = eq_q;
        big_d   = big_q;
        ovfl_d  = ovfl_q;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        case (state_q)
            S_BOOT: begin
                if (!mem_req) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = baddr_q;
                    wdata_d = '0;
                end else if (mem_ready) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    baddr_d = baddr_q + STEP;
                    state_d = baddr_q == LAST ? S_FETCH : S_BOOT;
                end
            end
            S_FETCH: begin
                if (!mem_req) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end else if (mem_ready) begin
                    req_d   = 1'b0;
                    inst_d  = mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_step;
                case (opcode)
                    OP_LDI: regs_d[ri] = WORD_SIZE'(opnd);
                    OP_LDD, OP_STO: begin
                        pc_d    = pc_q;
                        addr_d  = opnd[ADDR_SIZE-1:0];
                        state_d = S_MEM;
                    end
                    OP_LDX: begin
                        pc_d    = pc_q;
                        addr_d  = regs_q[rj][ADDR_SIZE-1:0];
                        state_d = S_MEM;
                    end
                    OP_ADD, OP_SUB: begin
                        regs_d[ri] = alu_res;
                        ovfl_d     = alu_ovfl;
                        eq_d       = alu_eq;
                        big_d      = alu_big;
                    end
                    OP_CMP: begin
                        eq_d  = alu_eq;
                        big_d = alu_big;
                    end
                    OP_JMPU: pc_d = opnd[ADDR_SIZE-1:0];
                    OP_JMPC: pc_d = cond_met(fld, eq_q, big_q, ovfl_q) ? opnd[ADDR_SIZE-1:0] : pc_step;
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (!mem_req) begin
                    req_d   = 1'b1;
                    we_d    = opcode == OP_STO;
                    wdata_d = regs_q[ri];
                end else if (mem_ready) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    pc_d    = pc_step;
                    state_d = S_FETCH;
                    if (opcode != OP_STO) regs_d[ri] = mem_rdata;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_core_hs.sv
// tb_cpu_core_hs: directed programs on the core, checked against an instruction-level model of the bus traffic.
module tb_cpu_core_hs;
    localparam int LDI = 1, LDD = 2, LDX = 3, STO = 4, ADD = 5, SUB = 6, CMP = 7, JMPU = 8, JMPC = 9, HLT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic mem_req, mem_we, mem_ready, boot, halted;

    logic [15:0] rom [0:63];
    logic [15:0] ram [0:255];

    typedef struct { int addr; bit we; int data; bit bt; } txn_t;
    txn_t exp_q[$];

    int vectors = 0, miscompares = 0, lat = 0, wait_cnt = 0, boot_wr = 0;
    bit active = 1'b0, prev_req = 1'b0, prev_acc = 1'b0, prev_we = 1'b0;
    logic [7:0] prev_addr = '0;
    logic [15:0] prev_wdata = '0;

    cpu_core_hs #(.WORD_SIZE(16), .ADDR_SIZE(8), .NUM_REGS(4), .BOOT_EN(1)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready), .boot(boot), .halted(halted)
    );

    always #5 clk = ~clk;

    // Addresses below 0x40 are program ROM (writes ignored); the rest is RAM.
    assign mem_rdata = mem_addr < 8'h40 ? rom[mem_addr[5:0]] : ram[mem_addr];
    assign mem_ready = wait_cnt >= lat;

    always @(posedge clk) begin
        wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
        if (rst) begin
            for (int k = 0; k < 256; k++) ram[k] <= 16'hDEAD;
        end else if (mem_req && mem_ready && mem_we && mem_addr >= 8'h40) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    function automatic void chk(input bit ok, input string name, input int act, input int exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] enc(input int op, input int f, input int o);
        return 16'((op << 11) | (f << 8) | o);
    endfunction

    function automatic int sx(input int x);
        return x >= 32768 ? x - 65536 : x;
    endfunction

    // Instruction-level model: the ordered list of bus accesses the program must produce.
    task automatic model_run();
        int m [256];
        int r [4];
        bit eq = 0, big = 0, ov = 0, t;
        int pc = 0, nxt, op, f, o, i, j, a, s;
        exp_q.delete();
        for (int k = 0; k < 256; k += 2) exp_q.push_back('{addr: k, we: 1'b1, data: 0, bt: 1'b1});
        for (int k = 0; k < 256; k++) m[k] = k < 64 ? int'(rom[k]) : 0;
        for (int k = 0; k < 4; k++) r[k] = 0;
        for (int n = 0; n < 200; n++) begin
            exp_q.push_back('{addr: pc, we: 1'b0, data: 0, bt: 1'b0});
            op = m[pc] >> 11;
            f = (m[pc] >> 8) & 7;
            o = m[pc] & 255;
            i = f % 4;
            j = (o & 7) % 4;
            nxt = (pc + 2) % 256;
            if (op == HLT) break;
            case (op)
                LDI: r[i] = o;
                LDD: begin exp_q.push_back('{addr: o, we: 1'b0, data: 0, bt: 1'b0}); r[i] = m[o]; end
                LDX: begin a = r[j] % 256; exp_q.push_back('{addr: a, we: 1'b0, data: 0, bt: 1'b0}); r[i] = m[a]; end
                STO: begin exp_q.push_back('{addr: o, we: 1'b1, data: r[i], bt: 1'b0}); if (o >= 64) m[o] = r[i]; end
                ADD, SUB: begin
                    s = op == ADD ? sx(r[i]) + sx(r[j]) : sx(r[i]) - sx(r[j]);
                    ov = s > 32767 || s < -32768;
                    r[i] = s & 32'hFFFF;
                    eq = r[i] == 0;
                    big = r[i] != 0 && r[i] < 32768;
                end
                CMP: begin eq = r[i] == r[j]; big = r[i] > r[j]; end
                JMPU: nxt = o;
                JMPC: begin
                    case (f)
                        0: t = eq;
                        1: t = !eq;
                        2: t = big;
                        3: t = big || eq;
                        4: t = !big && !eq;
                        5: t = !big || eq;
                        6: t = ov;
                        default: t = !ov;
                    endcase
                    if (t) nxt = o;
                end
                default: ;
            endcase
            pc = nxt;
        end
    endtask

    always @(negedge clk) begin : cmp
        txn_t t;
        if (rst || !active) begin
            prev_req <= 1'b0;
            prev_acc <= 1'b0;
            boot_wr  <= 0;
        end else begin
            if (prev_acc) chk(!mem_req, "idle_gap", int'(mem_req), 0);
            if (prev_req && !prev_acc) begin
                chk(mem_req, "hold_req", int'(mem_req), 1);
                chk(mem_addr == prev_addr, "hold_addr", int'(mem_addr), int'(prev_addr));
                chk(mem_we == prev_we, "hold_we", int'(mem_we), int'(prev_we));
                chk(mem_wdata == prev_wdata, "hold_wdata", int'(mem_wdata), int'(prev_wdata));
            end
            if (halted) chk(!mem_req, "halt_req", int'(mem_req), 0);
            if (mem_req && mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_access", int'(mem_addr), -1);
                end else begin
                    t = exp_q.pop_front();
                    chk(int'(mem_addr) == t.addr, "addr", int'(mem_addr), t.addr);
                    chk(mem_we == t.we, "we", int'(mem_we), int'(t.we));
                    chk(boot == t.bt, "boot", int'(boot), int'(t.bt));
                    if (t.we) chk(int'(mem_wdata) == t.data, "wdata", int'(mem_wdata), t.data);
                end
                if (boot && mem_we) boot_wr <= boot_wr + 1;
            end
            prev_req   <= mem_req;
            prev_acc   <= mem_req && mem_ready;
            prev_addr  <= mem_addr;
            prev_we    <= mem_we;
            prev_wdata <= mem_wdata;
        end
    end

    task automatic clear_rom();
        for (int k = 0; k < 64; k++) rom[k] = '0;
    endtask

    task automatic start(input string nm, input int l, input int exp_len);
        rst = 1'b1;
        active = 1'b0;
        lat = l;
        model_run();
        chk(exp_q.size() == exp_len, {nm, "_model_len"}, exp_q.size(), exp_len);
        repeat (2) @(posedge clk);
        #1;
        chk(mem_req == 1'b0, {nm, "_rst_req"}, int'(mem_req), 0);
        chk(mem_we == 1'b0, {nm, "_rst_we"}, int'(mem_we), 0);
        chk(mem_addr == 8'h00, {nm, "_rst_addr"}, int'(mem_addr), 0);
        chk(mem_wdata == 16'h0, {nm, "_rst_wdata"}, int'(mem_wdata), 0);
        chk(boot == 1'b1, {nm, "_rst_boot"}, int'(boot), 1);
        chk(halted == 1'b0, {nm, "_rst_halted"}, int'(halted), 0);
        rst = 1'b0;
        active = 1'b1;
    endtask

    task automatic finish_run(input string nm);
        int n = 0;
        while (!halted && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk(halted == 1'b1, {nm, "_halt_timeout"}, int'(halted), 1);
        repeat (4) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, {nm, "_pending"}, exp_q.size(), 0);
        chk(boot_wr == 128, {nm, "_boot_writes"}, boot_wr, 128);
    endtask

    task automatic load_p1();
        clear_rom();
        rom[0] = enc(LDI, 0, 5);
        rom[2] = enc(LDI, 1, 3);
        rom[4] = enc(ADD, 0, 1);
        rom[6] = enc(STO, 0, 'h40);
        rom[8] = enc(HLT, 0, 0);
    endtask

    initial begin
        int n;
        load_p1();
        start("p1", 0, 134);
        finish_run("p1");
        chk(ram[8'h40] == 16'd8, "p1_mem40", int'(ram[8'h40]), 8);

        load_p1();
        start("p1w", 3, 134);
        finish_run("p1w");
        chk(ram[8'h40] == 16'd8, "p1w_mem40", int'(ram[8'h40]), 8);

        clear_rom();
        rom[0]    = enc(LDD, 0, 'h30);
        rom[2]    = enc(LDI, 1, 1);
        rom[4]    = enc(ADD, 0, 1);
        rom[6]    = enc(JMPC, 6, 'h20);
        rom[8]    = enc(HLT, 0, 0);
        rom['h20] = enc(STO, 0, 'h40);
        rom['h22] = enc(JMPU, 0, 'h26);
        rom['h24] = enc(HLT, 0, 0);
        rom['h26] = enc(HLT, 0, 0);
        rom['h30] = 16'h7FFF;
        start("p2", 0, 137);
        finish_run("p2");
        chk(ram[8'h40] == 16'h8000, "p2_mem40", int'(ram[8'h40]), 'h8000);

        clear_rom();
        rom[0]    = enc(LDI, 0, 4);
        rom[2]    = enc(LDI, 1, 9);
        rom[4]    = enc(CMP, 0, 1);
        rom[6]    = enc(JMPC, 4, 'h10);
        rom[8]    = enc(HLT, 0, 0);
        rom['h10] = enc(LDI, 0, 9);
        rom['h12] = enc(CMP, 0, 1);
        rom['h14] = enc(JMPC, 2, 'h30);
        rom['h16] = enc(LDI, 3, 'h30);
        rom['h18] = enc(LDX, 2, 3);
        rom['h1A] = enc(SUB, 2, 1);
        rom['h1C] = enc(STO, 2, 'h42);
        rom['h1E] = enc(STO, 0, 'h44);
        rom['h20] = enc(HLT, 0, 0);
        rom['h30] = 16'h1234;
        start("p3", 1, 144);
        finish_run("p3");
        chk(ram[8'h42] == 16'h122B, "p3_mem42", int'(ram[8'h42]), 'h122B);
        chk(ram[8'h44] == 16'd9, "p3_mem44", int'(ram[8'h44]), 9);

        clear_rom();
        rom[0]  = enc(LDI, 0, 5);
        rom[2]  = enc(LDI, 1, 6);
        rom[4]  = enc(LDI, 2, 7);
        rom[6]  = enc(LDI, 3, 8);
        rom[8]  = enc(STO, 3, 'h40);
        rom[10] = enc(HLT, 0, 0);
        start("p4", 3, 135);
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_req && mem_we && !boot) break;
        end
        chk(mem_req && mem_we && !boot, "p4_store_req_seen", int'(mem_req), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk(mem_req == 1'b0, "midrst_req", int'(mem_req), 0);
        chk(mem_we == 1'b0, "midrst_we", int'(mem_we), 0);
        chk(boot == 1'b1, "midrst_boot", int'(boot), 1);

        clear_rom();
        rom[0] = enc(STO, 0, 'h40);
        rom[2] = enc(STO, 1, 'h42);
        rom[4] = enc(STO, 2, 'h44);
        rom[6] = enc(STO, 3, 'h46);
        rom[8] = enc(HLT, 0, 0);
        start("p5", 0, 137);
        finish_run("p5");
        chk(ram[8'h46] == 16'h0, "p5_mem46", int'(ram[8'h46]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
